// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding the write FIFO toward the SDRAM write
// controller. The line is synchronised through three flops. Each bit is
// sampled at its midpoint by a free-running baud counter. Good bytes are
// written into the FIFO. Framing errors and bytes lost to a full FIFO are
// reported as single-cycle pulses.
module uart_rx #(
   parameter int BAUD_END = 5207,
   parameter int BAUD_M   = BAUD_END / 2 - 1,
   parameter int BIT_END  = 7
) (
   input  logic       sclk,
   input  logic       s_rst,
   input  logic       rs232_rx,
   input  logic       wfifo_full,
   output logic       wfifo_wr_en,
   output logic [7:0] wfifo_wr_data,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overflow
);

   localparam logic [12:0] BAUD_END_C = 13'(BAUD_END);
   localparam logic [12:0] BAUD_M_C   = 13'(BAUD_M);
   localparam logic [2:0]  BIT_END_C  = 3'(BIT_END);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic        rx_r1_q, rx_r2_q, rx_r3_q;
   logic [1:0]  state_q, state_d;
   logic [12:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        wr_en_q, wr_en_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        busy_q, busy_d;
   logic        ferr_q, ferr_d;
   logic        ovf_q, ovf_d;

   logic fall_edge, baud_mid, baud_last;

   assign fall_edge = !rx_r2_q && rx_r3_q;
   assign baud_mid  = (baud_cnt_q == BAUD_M_C);
   assign baud_last = (baud_cnt_q == BAUD_END_C);

   // Next-state logic: frame FSM, baud/bit counters, shifter and output pulses
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      ferr_d    = 1'b0;
      ovf_d     = 1'b0;
      if (state_q == IDLE || baud_last) begin
         baud_cnt_d = 13'd0;
      end else begin
         baud_cnt_d = baud_cnt_q + 13'd1;
      end

      case (state_q)
         IDLE: begin
            if (fall_edge) begin
               state_d = START;
            end
         end
         START: begin
            // A start bit that is high again at its midpoint was a glitch
            if (baud_mid && rx_r2_q) begin
               state_d    = IDLE;
               baud_cnt_d = 13'd0;
            end else if (baud_last) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (baud_mid) begin
               shift_d = {rx_r2_q, shift_q[7:1]};
            end
            if (baud_last) begin
               if (bit_cnt_q == BIT_END_C) begin
                  state_d = STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         STOP: begin
            // Leave half a bit early so the next start edge is never missed
            if (baud_mid) begin
               state_d    = IDLE;
               baud_cnt_d = 13'd0;
               if (!rx_r2_q) begin
                  ferr_d = 1'b1;
               end else if (wfifo_full) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_data_d = shift_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // Register stage: line synchroniser plus all state and outputs
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         rx_r1_q    <= 1'b1;
         rx_r2_q    <= 1'b1;
         rx_r3_q    <= 1'b1;
         state_q    <= IDLE;
         baud_cnt_q <= 13'd0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'd0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= 8'd0;
         busy_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         rx_r1_q    <= rs232_rx;
         rx_r2_q    <= rx_r1_q;
         rx_r3_q    <= rx_r2_q;
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         wr_en_q    <= wr_en_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         ferr_q     <= ferr_d;
         ovf_q      <= ovf_d;
      end
   end

   assign wfifo_wr_en   = wr_en_q;
   assign wfifo_wr_data = wr_data_q;
   assign rx_busy       = busy_q;
   assign frame_err     = ferr_q;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames on the line and compares every output pulse
// against a frame-level model. The model computes each outcome from the
// frame contents: a write, an overflow, a framing error, or nothing. It also
// gives the cycle of each outcome: stop-bit midpoint plus 3 cycles.
module tb_uart_rx;
   localparam int BAUD_END = 56;
   localparam int BIT_CYC  = BAUD_END + 1;
   localparam int LAT      = 9 * BIT_CYC + BIT_CYC / 2 + 3;

   logic       sclk = 1'b0;
   logic       s_rst;
   logic       rs232_rx;
   logic       wfifo_full;
   logic       wfifo_wr_en;
   logic [7:0] wfifo_wr_data;
   logic       rx_busy;
   logic       frame_err;
   logic       overflow;

   uart_rx #(.BAUD_END(BAUD_END)) dut (
      .sclk          (sclk),
      .s_rst         (s_rst),
      .rs232_rx      (rs232_rx),
      .wfifo_full    (wfifo_full),
      .wfifo_wr_en   (wfifo_wr_en),
      .wfifo_wr_data (wfifo_wr_data),
      .rx_busy       (rx_busy),
      .frame_err     (frame_err),
      .overflow      (overflow)
   );

   always #5 sclk = ~sclk;

   int unsigned cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   // kind: 0 = write, 1 = overflow, 2 = frame error
   typedef struct {
      int          kind;
      int          data;
      int unsigned at;
      int          busy;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   int  total = 0;
   int  bad   = 0;
   logic [7:0] last_byte = 8'd0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Record every cycle any output pulse is high
   always @(negedge sclk) begin
      ev_t e;
      e.at   = cyc;
      e.busy = int'(rx_busy);
      if (wfifo_wr_en === 1'b1) begin
         e.kind = 0; e.data = int'(wfifo_wr_data); obs_q.push_back(e);
      end
      if (overflow === 1'b1) begin
         e.kind = 1; e.data = 0; obs_q.push_back(e);
      end
      if (frame_err === 1'b1) begin
         e.kind = 2; e.data = 0; obs_q.push_back(e);
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge sclk);
      #1;
   endtask

   task automatic hold_bit(input logic v);
      rs232_rx = v;
      wait_cycles(BIT_CYC);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit full, input int gap);
      int unsigned t0;
      ev_t e;
      wfifo_full = full;
      t0 = cyc;
      hold_bit(1'b0);
      check_val("busy_mid", rx_busy, 1);
      for (int i = 0; i < 8; i++) hold_bit(b[i]);
      hold_bit(stop_ok);
      rs232_rx = 1'b1;
      if (gap > 0) wait_cycles(gap);
      e.at = t0 + LAT; e.busy = 0; e.data = 0;
      if (!stop_ok) e.kind = 2;
      else if (full) e.kind = 1;
      else begin
         e.kind = 0; e.data = int'(b); last_byte = b;
      end
      exp_q.push_back(e);
      $display("frame %02h stop_ok=%0d full=%0d kind=%0d", b, stop_ok, full, e.kind);
   endtask

   task automatic drain(input string phase);
      int n;
      wait_cycles(5);
      check_val({phase, "_ev_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check_val({phase, "_kind"}, obs_q[i].kind, exp_q[i].kind);
         check_val({phase, "_data"}, obs_q[i].data, exp_q[i].data);
         check_val({phase, "_cycle"}, obs_q[i].at, exp_q[i].at);
         check_val({phase, "_busy"}, obs_q[i].busy, exp_q[i].busy);
      end
      check_val({phase, "_data_hold"}, wfifo_wr_data, last_byte);
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string phase);
      check_val({phase, "_wr_en"}, wfifo_wr_en, 0);
      check_val({phase, "_wr_data"}, wfifo_wr_data, 0);
      check_val({phase, "_busy"}, rx_busy, 0);
      check_val({phase, "_ferr"}, frame_err, 0);
      check_val({phase, "_ovf"}, overflow, 0);
   endtask

   initial begin
      ev_t e;
      int unsigned t0;
      logic [7:0] rb;
      bit ok, full;

      s_rst = 1'b1; rs232_rx = 1'b1; wfifo_full = 1'b0;
      wait_cycles(3);
      check_reset_outputs("reset");
      s_rst = 1'b0;
      wait_cycles(10);
      obs_q.delete();

      // Single clean byte
      send_frame(8'h55, 1, 0, 20);
      drain("t1");

      // Back-to-back frames with one stop bit
      send_frame(8'hA3, 1, 0, 0);
      send_frame(8'h0F, 1, 0, 0);
      send_frame(8'hFF, 1, 0, 20);
      drain("t2");

      // Short low glitch on an idle line
      rs232_rx = 1'b0;
      wait_cycles(10);
      rs232_rx = 1'b1;
      check_val("glitch_busy", rx_busy, 1);
      wait_cycles(100);
      check_val("glitch_idle", rx_busy, 0);
      drain("t3");

      // Stop bit forced low
      send_frame(8'h3C, 0, 0, 20);
      drain("t4");

      // FIFO full, then recovery
      send_frame(8'h81, 1, 1, 0);
      send_frame(8'h7E, 1, 0, 20);
      drain("t5");

      // Reset in the middle of data bit 4
      rb = 8'hC6;
      hold_bit(1'b0);
      for (int i = 0; i < 4; i++) hold_bit(rb[i]);
      rs232_rx = rb[4];
      wait_cycles(BIT_CYC / 2);
      rs232_rx = 1'b1;
      s_rst = 1'b1;
      wait_cycles(1);
      check_reset_outputs("midrst");
      wait_cycles(1);
      s_rst = 1'b0;
      last_byte = 8'd0;
      wait_cycles(700);
      drain("t6a");
      send_frame(8'h42, 1, 0, 20);
      drain("t6b");

      // Break: line held low well beyond one frame
      t0 = cyc;
      rs232_rx = 1'b0;
      wait_cycles(1500);
      rs232_rx = 1'b1;
      wait_cycles(100);
      e.kind = 2; e.data = 0; e.at = t0 + LAT; e.busy = 0;
      exp_q.push_back(e);
      check_val("break_idle", rx_busy, 0);
      drain("brk");

      // Randomised frames
      for (int k = 0; k < 20; k++) begin
         rb   = 8'($urandom);
         ok   = ($urandom % 5) != 0;
         full = ($urandom % 4) == 0;
         send_frame(rb, ok, full, ok ? int'($urandom % 8) : 3 + int'($urandom % 8));
      end
      drain("rnd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
